// File: rtl/im_loader_pkg.sv
// Shared encodings and framing constants for the instruction-memory boot loader.
package im_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_CHK, ST_DONE, ST_ERR
  } ld_state_e;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int CSUM_W     = 8;

  function automatic logic is_busy(ld_state_e s);
    return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/im_boot_loader_packer.sv
// Shifts bytes MSB-first into a 32-bit word; word_vld_o pulses the cycle after the 4th byte.
module byte_word_packer
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_vld_o,
  output logic        last_o
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;
  logic        vld_q;

  // Combinational so the owner can update its word index on the same edge.
  assign last_o     = byte_vld_i && (cnt_q == 2'(WORD_BYTES - 1));
  assign word_o     = word_q;
  assign word_vld_o = vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= last_o;
      if (clr) begin
        cnt_q <= '0;
      end else if (byte_vld_i) begin
        word_q <= {word_q[23:0], byte_i};
        cnt_q  <= cnt_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/im_boot_loader.sv
// Loads a framed, checksummed byte stream into instruction memory and holds the CPU
// in reset until a complete, valid frame has been written.
module im_boot_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int DEPTH     = 1024,
  parameter int TIMEOUT   = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 im_we,
  output logic [ADDR_BITS-1:0] im_addr,
  output logic [31:0]          im_wdata,
  output logic                 cpu_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_BITS:0]   words_loaded
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int NW = HDR_BYTES * 8;

  ld_state_e              state_q, state_d;
  logic [NW-1:0]          n_q, n_full;
  logic [CSUM_W-1:0]      csum_q;
  logic [TW-1:0]          tmo_q;
  logic [ADDR_BITS:0]     wl_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   busy_q, done_q, err_q, cpu_rst_n_q;
  logic                   acc, pk_last, pk_vld;
  logic [NW:0]            wl_inc;

  assign in_ready     = busy_q && !start && !pk_vld;
  assign acc          = in_valid && in_ready;
  assign n_full       = {n_q[NW-1:8], in_data};
  assign wl_inc       = (NW+1)'(wl_q) + (NW+1)'(1);
  assign im_we        = pk_vld;
  assign im_addr      = addr_q;
  assign words_loaded = wl_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = err_q;
  assign cpu_rst_n    = cpu_rst_n_q;

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start),
    .byte_vld_i (acc && (state_q == ST_DATA)),
    .byte_i     (in_data),
    .word_o     (im_wdata),
    .word_vld_o (pk_vld),
    .last_o     (pk_last)
  );

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_HDR_HI;
    end else begin
      case (state_q)
        ST_HDR_HI: if (acc) state_d = ST_HDR_LO;
        ST_HDR_LO: if (acc) begin
          if (n_full == '0)                      state_d = ST_CHK;
          else if (32'(n_full) > 32'(DEPTH))     state_d = ST_ERR;
          else                                   state_d = ST_DATA;
        end
        // The final write still occupies the next cycle; in_ready is low there anyway.
        ST_DATA:   if (acc && pk_last && (wl_inc == {1'b0, n_q})) state_d = ST_CHK;
        ST_CHK:    if (acc) state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
        default:   ;
      endcase
      if (busy_q && !acc && (tmo_q == TW'(TIMEOUT - 1))) state_d = ST_ERR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      wl_q        <= '0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= is_busy(state_d);
      done_q      <= (state_d == ST_DONE);
      err_q       <= (state_d == ST_ERR);
      cpu_rst_n_q <= (state_d == ST_DONE);
      if (start) begin
        n_q    <= '0;
        csum_q <= '0;
        tmo_q  <= '0;
        wl_q   <= '0;
      end else begin
        if (acc)         tmo_q <= '0;
        else if (busy_q) tmo_q <= tmo_q + TW'(1);
        if (acc) begin
          case (state_q)
            ST_HDR_HI: n_q[NW-1:8] <= in_data;
            ST_HDR_LO: n_q[7:0]    <= in_data;
            ST_DATA: begin
              csum_q <= csum_q ^ in_data;
              if (pk_last) begin
                addr_q <= wl_q[ADDR_BITS-1:0];
                wl_q   <= wl_q + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_im_boot_loader.sv
// Directed checks of the boot loader: framing, checksum, size limits, timeout, restart, reset.
module tb_im_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, im_we, cpu_rst_n, busy, done, error;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic [10:0] words_loaded;

  int total = 0;
  int fails = 0;
  int bp_viol = 0;
  logic [9:0]  waddr[$];
  logic [31:0] wdata[$];

  im_boot_loader #(.ADDR_BITS(10), .DEPTH(1024), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Record every write and any cycle where a byte could be taken during a write.
  always @(negedge clk) begin
    if (im_we) begin
      waddr.push_back(im_addr);
      wdata.push_back(im_wdata);
      if (in_ready) bp_viol++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Holds in_valid until the byte is taken; back-to-back calls keep in_valid high.
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("send_stall", 64'(n), 64'd0);
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic clear_log();
    waddr.delete();
    wdata.delete();
  endtask

  initial begin
    #12;
    chk("reset_outputs", {in_ready, im_we, im_addr, im_wdata, cpu_rst_n, busy, done, error, words_loaded}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Two-word load with in_valid held high throughout the payload
    clear_log();
    pulse_start();
    chk("start_busy", {busy, cpu_rst_n, done}, 3'b100);
    send(8'h00); send(8'h02);
    send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    send(8'hFC); send(8'h00); send(8'h00); send(8'h00);
    send(8'hD1);
    chk("ok_nwrites", 64'(waddr.size()), 64'd2);
    if (waddr.size() == 2) begin
      chk("ok_w0", {waddr[0], wdata[0]}, {10'd0, 32'h20080005});
      chk("ok_w1", {waddr[1], wdata[1]}, {10'd1, 32'hFC000000});
    end
    chk("ok_status", {done, error, cpu_rst_n, busy, in_ready}, 5'b10100);
    chk("ok_words_loaded", 64'(words_loaded), 64'd2);
    chk("ok_hold_addr_data", {im_addr, im_wdata}, {10'd1, 32'hFC000000});
    chk("ok_backpressure", 64'(bp_viol), 64'd0);

    // Same frame, wrong checksum: writes stay, CPU stays in reset
    clear_log();
    pulse_start();
    chk("restart_from_done", {busy, done, cpu_rst_n}, 3'b100);
    send(8'h00); send(8'h02);
    send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    send(8'hFC); send(8'h00); send(8'h00); send(8'h00);
    send(8'h00);
    chk("badck_nwrites", 64'(waddr.size()), 64'd2);
    chk("badck_status", {done, error, cpu_rst_n, busy}, 4'b0100);
    chk("badck_words_loaded", 64'(words_loaded), 64'd2);

    // Oversize header: N = 1025
    clear_log();
    pulse_start();
    send(8'h04);
    chk("over_after_hi", {busy, error}, 2'b10);
    send(8'h01);
    chk("over_err", {error, busy, done, cpu_rst_n}, 4'b1000);
    chk("over_nwrites", 64'(waddr.size()), 64'd0);

    // Empty frame
    clear_log();
    pulse_start();
    send(8'h00); send(8'h00); send(8'h00);
    chk("empty_done", {done, error, cpu_rst_n}, 3'b101);
    chk("empty_words_loaded", 64'(words_loaded), 64'd0);
    chk("empty_nwrites", 64'(waddr.size()), 64'd0);

    // Timeout: stall after two payload bytes
    clear_log();
    pulse_start();
    send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
    repeat (15) @(posedge clk);
    #1 chk("tmo_before", {error, busy}, 2'b01);
    @(posedge clk);
    #1 chk("tmo_after", {error, busy, done, cpu_rst_n}, 4'b1000);
    chk("tmo_nwrites", 64'(waddr.size()), 64'd0);

    // Restart in the middle of DATA, then a clean frame
    clear_log();
    pulse_start();
    send(8'h00); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    chk("mid_words_loaded", 64'(words_loaded), 64'd1);
    pulse_start();
    chk("mid_restart", {busy, done, error, words_loaded}, {3'b100, 11'd0});
    clear_log();
    send(8'h00); send(8'h01);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send(8'h22);
    chk("mid_nwrites", 64'(waddr.size()), 64'd1);
    if (waddr.size() == 1) chk("mid_w0", {waddr[0], wdata[0]}, {10'd0, 32'hDEADBEEF});
    chk("mid_done", {done, cpu_rst_n, words_loaded}, {2'b11, 11'd1});

    // Asynchronous reset between edges during DATA
    clear_log();
    pulse_start();
    send(8'h00); send(8'h02); send(8'h01); send(8'h02);
    #2 rst = 1'b1;
    #1 chk("arst_outputs", {in_ready, im_we, im_addr, im_wdata, cpu_rst_n, busy, done, error, words_loaded}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk);
    #1 chk("arst_idle", {busy, done, error, in_ready, cpu_rst_n}, 5'b00000);
    in_valid = 1'b1; in_data = 8'h5A;
    @(posedge clk);
    #1 chk("arst_ignores_bytes", {busy, in_ready}, 2'b00);
    in_valid = 1'b0;
    pulse_start();
    send(8'h00); send(8'h00); send(8'h00);
    chk("arst_reload", {done, cpu_rst_n}, 2'b11);
    chk("final_backpressure", 64'(bp_viol), 64'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
